// File: rtl/booth_alu.sv
// Registered ripple-carry add/subtract datapath for the Booth multiplier.
// Optional macro ALU_SUB_EN adds a sub port that computes a - b internally.
module booth_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ALU_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

`ifdef ALU_SUB_EN
  // Subtract as a + ~b + 1; cin is ignored while sub is high.
  assign b_eff = sub ? ~b : b;
  assign c[0]  = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c[0]  = cin;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b_eff[i] ^ c[i];
    assign c[i+1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
  end

  // Result registers load only on in_valid, so X on idle inputs never reaches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= s;
        cout <= c[WIDTH];
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
        zero <= (s == '0);
      end
    end
  end

endmodule

// File: tb/tb_booth_alu.sv
// Directed self-checking bench for booth_alu (WIDTH=8), hand-computed vectors.
module tb_booth_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef ALU_SUB_EN
  logic       sub;
`endif
  logic [7:0] out;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef ALU_SUB_EN
    .sub      (sub),
`endif
    .out      (out),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and sample outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_out, input logic e_cout,
                           input logic e_ovf, input logic e_zero, input logic e_valid);
    check({tag, ".out"},       32'(out),       32'(e_out));
    check({tag, ".cout"},      32'(cout),      32'(e_cout));
    check({tag, ".ovf"},       32'(ovf),       32'(e_ovf));
    check({tag, ".zero"},      32'(zero),      32'(e_zero));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
  endtask

  task automatic run_vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vcin, input logic [7:0] e_out, input logic e_cout,
                         input logic e_ovf, input logic e_zero);
    a        = va;
    b        = vb;
    cin      = vcin;
    in_valid = 1'b1;
    tick();
    check_all(tag, e_out, e_cout, e_ovf, e_zero, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'hFF;
    cin      = 1'b0;
`ifdef ALU_SUB_EN
    sub      = 1'b0;
`endif
    // Reset wins over in_valid for two edges.
    tick();
    check_all("rst0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("rst1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back vectors, one per cycle.
    run_vec("add",     8'hAA, 8'h4B, 1'b0, 8'hF5, 1'b0, 1'b0, 1'b0);
    run_vec("boothsub",8'h05, 8'hF8, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_vec("wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_vec("ovfpos",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_vec("ovfneg",  8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_vec("cinonly", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    run_vec("fullcy",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

`ifdef ALU_SUB_EN
    sub = 1'b1;
    run_vec("sub",     8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_vec("subeq",   8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    sub = 1'b0;
`endif

    // Hold: drop in_valid and drive X on operands; result must persist.
    run_vec("cap",     8'hAA, 8'h4B, 1'b0, 8'hF5, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    cin      = 1'bx;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("hold%0d", i), 8'hF5, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Mid-operation reset discards the pending capture.
    a        = 8'h7F;
    b        = 8'h01;
    cin      = 1'b0;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    check_all("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check_all("postrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
